// File: rtl/nvdla_noc_axi_pkg.sv
// Shared types for the MCIF NoC AXI-subset responder: request record and FSM states.
package nvdla_noc_axi_pkg;

    localparam int AXI_ID_W   = 8;
    localparam int AXI_LEN_W  = 4;
    // Queued requests keep a full 64-bit address; only the word-index bits are consumed.
    localparam int AXI_ADDR_W = 64;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_LEN_W-1:0]  len;
        logic [AXI_ADDR_W-1:0] addr;
    } axi_req_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/nvdla_noc_axi_req_fifo.sv
// Small synchronous request FIFO (power-of-2 depth >= 2) with show-ahead output.
module nvdla_noc_axi_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 76
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/nvdla_noc_axi_responder.sv
// Memory-side AXI-subset responder for the MCIF NoC port: queued AR/AW, in-order R/B
// served from a word-addressed byte-writable array.
module nvdla_noc_axi_responder
    import nvdla_noc_axi_pkg::*;
#(
    parameter int ADDR_W        = 64,
    parameter int DATA_W        = 512,
    parameter int STRB_W        = DATA_W / 8,
    parameter int MEM_DEPTH     = 256,
    parameter int AR_FIFO_DEPTH = 4,
    parameter int AW_FIFO_DEPTH = 4
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              mcif2noc_axi_ar_arvalid,
    output logic              mcif2noc_axi_ar_arready,
    input  logic [7:0]        mcif2noc_axi_ar_arid,
    input  logic [3:0]        mcif2noc_axi_ar_arlen,
    input  logic [ADDR_W-1:0] mcif2noc_axi_ar_araddr,
    output logic              noc2mcif_axi_r_rvalid,
    input  logic              noc2mcif_axi_r_rready,
    output logic [7:0]        noc2mcif_axi_r_rid,
    output logic              noc2mcif_axi_r_rlast,
    output logic [DATA_W-1:0] noc2mcif_axi_r_rdata,
    input  logic              mcif2noc_axi_aw_awvalid,
    output logic              mcif2noc_axi_aw_awready,
    input  logic [7:0]        mcif2noc_axi_aw_awid,
    input  logic [3:0]        mcif2noc_axi_aw_awlen,
    input  logic [ADDR_W-1:0] mcif2noc_axi_aw_awaddr,
    input  logic              mcif2noc_axi_w_wvalid,
    output logic              mcif2noc_axi_w_wready,
    input  logic [DATA_W-1:0] mcif2noc_axi_w_wdata,
    input  logic [STRB_W-1:0] mcif2noc_axi_w_wstrb,
    input  logic              mcif2noc_axi_w_wlast,
    output logic              noc2mcif_axi_b_bvalid,
    input  logic              noc2mcif_axi_b_bready,
    output logic [7:0]        noc2mcif_axi_b_bid,
    output logic              wlast_err
);

    localparam int BYTE_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam int REQ_W    = $bits(axi_req_t);

    // ---------------- request queues ----------------
    axi_req_t ar_push_req, ar_head, aw_push_req, aw_head;
    logic     ar_full, ar_empty, ar_pop;
    logic     aw_full, aw_empty, aw_pop;
    logic     ar_push, aw_push;

    assign mcif2noc_axi_ar_arready = !ar_full && !nvdla_core_rst;
    assign mcif2noc_axi_aw_awready = !aw_full && !nvdla_core_rst;
    assign ar_push = mcif2noc_axi_ar_arvalid && mcif2noc_axi_ar_arready;
    assign aw_push = mcif2noc_axi_aw_awvalid && mcif2noc_axi_aw_awready;

    assign ar_push_req = '{id: mcif2noc_axi_ar_arid, len: mcif2noc_axi_ar_arlen,
                           addr: AXI_ADDR_W'(mcif2noc_axi_ar_araddr)};
    assign aw_push_req = '{id: mcif2noc_axi_aw_awid, len: mcif2noc_axi_aw_awlen,
                           addr: AXI_ADDR_W'(mcif2noc_axi_aw_awaddr)};

    nvdla_noc_axi_req_fifo #(.DEPTH(AR_FIFO_DEPTH), .WIDTH(REQ_W)) u_ar_fifo (
        .clk       (nvdla_core_clk),
        .srst      (nvdla_core_rst),
        .push      (ar_push),
        .push_data (ar_push_req),
        .pop       (ar_pop),
        .pop_data  (ar_head),
        .full      (ar_full),
        .empty     (ar_empty)
    );

    nvdla_noc_axi_req_fifo #(.DEPTH(AW_FIFO_DEPTH), .WIDTH(REQ_W)) u_aw_fifo (
        .clk       (nvdla_core_clk),
        .srst      (nvdla_core_rst),
        .push      (aw_push),
        .push_data (aw_push_req),
        .pop       (aw_pop),
        .pop_data  (aw_head),
        .full      (aw_full),
        .empty     (aw_empty)
    );

    // Address bits above the word index deliberately take no part in addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ar_head.addr, aw_head.addr};

    // ---------------- memory ----------------
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]  rd_idx_reg, rd_idx_next;
    logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
    logic              mem_wr_en;

    // Combinational read with non-blocking write gives read-before-write on a collision.
    assign noc2mcif_axi_r_rdata = mem[rd_idx_reg];

    always_ff @(posedge nvdla_core_clk) begin
        if (mem_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (mcif2noc_axi_w_wstrb[b]) begin
                    mem[wr_idx_reg][b*8 +: 8] <= mcif2noc_axi_w_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read FSM ----------------
    rd_state_e        rd_state_reg, rd_state_next;
    logic [7:0]       rid_reg, rid_next;
    logic [3:0]       rd_len_reg, rd_len_next;
    logic [3:0]       rd_cnt_reg, rd_cnt_next;
    logic             rd_last;

    assign rd_last              = (rd_state_reg == R_BURST) && (rd_cnt_reg == rd_len_reg);
    assign noc2mcif_axi_r_rvalid = (rd_state_reg == R_BURST);
    assign noc2mcif_axi_r_rlast  = rd_last;
    assign noc2mcif_axi_r_rid    = rid_reg;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            rd_state_reg <= R_IDLE;
            rid_reg      <= '0;
            rd_len_reg   <= '0;
            rd_cnt_reg   <= '0;
            rd_idx_reg   <= '0;
        end else begin
            rd_state_reg <= rd_state_next;
            rid_reg      <= rid_next;
            rd_len_reg   <= rd_len_next;
            rd_cnt_reg   <= rd_cnt_next;
            rd_idx_reg   <= rd_idx_next;
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        rid_next      = rid_reg;
        rd_len_next   = rd_len_reg;
        rd_cnt_next   = rd_cnt_reg;
        rd_idx_next   = rd_idx_reg;
        ar_pop        = 1'b0;
        case (rd_state_reg)
            R_IDLE: begin
                if (!ar_empty) begin
                    ar_pop        = 1'b1;
                    rid_next      = ar_head.id;
                    rd_len_next   = ar_head.len;
                    rd_cnt_next   = '0;
                    rd_idx_next   = ar_head.addr[BYTE_LSB +: IDX_W];
                    rd_state_next = R_BURST;
                end
            end
            R_BURST: begin
                if (noc2mcif_axi_r_rready) begin
                    rd_idx_next = rd_idx_reg + 1'b1;
                    rd_cnt_next = rd_cnt_reg + 1'b1;
                    if (rd_last) begin
                        rd_state_next = R_IDLE;
                    end
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // ---------------- write FSM ----------------
    wr_state_e  wr_state_reg, wr_state_next;
    logic [7:0] bid_reg, bid_next;
    logic [3:0] wr_len_reg, wr_len_next;
    logic [3:0] wr_cnt_reg, wr_cnt_next;
    logic       wlast_err_reg, wlast_err_next;
    logic       wr_final_beat;

    assign wr_final_beat          = (wr_cnt_reg == wr_len_reg);
    assign mcif2noc_axi_w_wready  = (wr_state_reg == W_DATA);
    assign noc2mcif_axi_b_bvalid  = (wr_state_reg == W_RESP);
    assign noc2mcif_axi_b_bid     = bid_reg;
    assign wlast_err              = wlast_err_reg;
    assign mem_wr_en              = (wr_state_reg == W_DATA) && mcif2noc_axi_w_wvalid
                                    && !nvdla_core_rst;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wr_state_reg  <= W_IDLE;
            bid_reg       <= '0;
            wr_len_reg    <= '0;
            wr_cnt_reg    <= '0;
            wr_idx_reg    <= '0;
            wlast_err_reg <= 1'b0;
        end else begin
            wr_state_reg  <= wr_state_next;
            bid_reg       <= bid_next;
            wr_len_reg    <= wr_len_next;
            wr_cnt_reg    <= wr_cnt_next;
            wr_idx_reg    <= wr_idx_next;
            wlast_err_reg <= wlast_err_next;
        end
    end

    always_comb begin
        wr_state_next  = wr_state_reg;
        bid_next       = bid_reg;
        wr_len_next    = wr_len_reg;
        wr_cnt_next    = wr_cnt_reg;
        wr_idx_next    = wr_idx_reg;
        wlast_err_next = wlast_err_reg;
        aw_pop         = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                if (!aw_empty) begin
                    aw_pop        = 1'b1;
                    bid_next      = aw_head.id;
                    wr_len_next   = aw_head.len;
                    wr_cnt_next   = '0;
                    wr_idx_next   = aw_head.addr[BYTE_LSB +: IDX_W];
                    wr_state_next = W_DATA;
                end
            end
            W_DATA: begin
                if (mcif2noc_axi_w_wvalid) begin
                    wr_idx_next = wr_idx_reg + 1'b1;
                    wr_cnt_next = wr_cnt_reg + 1'b1;
                    // Burst length comes from awlen; wlast is only cross-checked.
                    if (mcif2noc_axi_w_wlast != wr_final_beat) begin
                        wlast_err_next = 1'b1;
                    end
                    if (wr_final_beat) begin
                        wr_state_next = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (noc2mcif_axi_b_bready) begin
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

endmodule
